// File: rtl/clkgen_prog.sv
// Serial M/D reprogramming controller for a DCM: shifts D then M over PROGEN/PROGDATA,
// issues GO, then waits for the PROGDONE low-to-high handshake or gives up after TIMEOUT.
`timescale 1ns/1ps
module clkgen_prog #(
    parameter int TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] mult,
    input  logic [7:0] div,
    input  logic       progdone,
    output logic       progen,
    output logic       progdata,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] cur_m,
    output logic [7:0] cur_d
);

    localparam int               CNT_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [3:0]       BIT_LAST  = 4'd9;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_D,
        GAP1,
        LOAD_M,
        GAP2,
        GO,
        WAIT_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       bit_cnt;
    logic [CNT_W-1:0] wait_cnt;
    logic             seen_low;
    logic             rej_pend;
    logic [7:0]       m_lat;
    logic [7:0]       d_lat;
    logic             accept;
    logic             reject;
    logic             complete;
    logic             timeout_hit;
    logic             load_last;
    logic [2:0]       data_idx;

    assign accept      = (state == IDLE) && start && (mult != 8'd0);
    assign reject      = (state == IDLE) && start && (mult == 8'd0);
    // Completion wins over a timeout landing on the same cycle.
    assign complete    = (state == WAIT_DONE) && seen_low && progdone;
    assign timeout_hit = (state == WAIT_DONE) && (wait_cnt == WAIT_LAST) && !complete;
    assign load_last   = (bit_cnt == BIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (accept) state_nxt = LOAD_D;
            LOAD_D:    if (load_last) state_nxt = GAP1;
            GAP1:      state_nxt = LOAD_M;
            LOAD_M:    if (load_last) state_nxt = GAP2;
            GAP2:      state_nxt = GO;
            GO:        state_nxt = WAIT_DONE;
            WAIT_DONE: if (complete || timeout_hit) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt  <= '0;
            wait_cnt <= '0;
            seen_low <= 1'b0;
            rej_pend <= 1'b0;
            cur_m    <= 8'd2;
            cur_d    <= 8'd0;
        end else begin
            rej_pend <= reject;
            if ((state == LOAD_D || state == LOAD_M) && !load_last) begin
                bit_cnt <= bit_cnt + 4'd1;
            end else begin
                bit_cnt <= '0;
            end
            if (state == WAIT_DONE && !complete && !timeout_hit) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
            // PROGDONE must be seen low once before a high level counts as completion.
            seen_low <= (state == WAIT_DONE) && !complete && !timeout_hit
                        && (seen_low || !progdone);
            if (complete) begin
                cur_m <= m_lat;
                cur_d <= d_lat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            m_lat <= mult;
            d_lat <= div;
        end
    end

    always_comb begin
        progen   = 1'b0;
        progdata = 1'b0;
        done     = complete;
        err      = rej_pend || timeout_hit;
        busy     = (state != IDLE) && !complete && !timeout_hit;
        data_idx = 3'(bit_cnt - 4'd2);
        case (state)
            LOAD_D: begin
                progen = 1'b1;
                if (bit_cnt == 4'd0) begin
                    progdata = 1'b1;
                end else if (bit_cnt == 4'd1) begin
                    progdata = 1'b0;
                end else begin
                    progdata = d_lat[data_idx];
                end
            end
            LOAD_M: begin
                progen = 1'b1;
                if (bit_cnt <= 4'd1) begin
                    progdata = 1'b1;
                end else begin
                    progdata = m_lat[data_idx];
                end
            end
            GO:      progen = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_clkgen_prog.sv
// Bench for clkgen_prog: a cycle-timeline model of the programming sequence checks every
// cycle, and directed scenarios pin the model with hand-computed serial patterns and timings.
`timescale 1ns/1ps
module tb_clkgen_prog;

    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] mult = 8'd0;
    logic [7:0] div = 8'd0;
    logic       progdone = 1'b1;
    logic       progen, progdata, busy, done, err;
    logic [7:0] cur_m, cur_d;

    clkgen_prog #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .mult(mult), .div(div),
        .progdone(progdone), .progen(progen), .progdata(progdata), .busy(busy),
        .done(done), .err(err), .cur_m(cur_m), .cur_d(cur_d)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: whether a request is in flight, and which cycle of its timeline we are in.
    bit         mb = 1'b0;
    int         mk = 0;
    bit         mrej = 1'b0;
    bit         mseen = 1'b0;
    logic [7:0] mlm = 8'd0, mld = 8'd0, mcm = 8'd2, mcd = 8'd0;

    function automatic logic ser_bit(input int i, input logic second, input logic [7:0] v);
        logic [9:0] f;
        f = {v, second, 1'b1};
        return f[i];
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mb = 0; mk = 0; mrej = 0; mseen = 0; mcm = 8'd2; mcd = 8'd0;
            end else if (!mb) begin
                mrej = start && (mult == 8'd0);
                if (start && mult != 8'd0) begin
                    mb = 1; mk = 1; mlm = mult; mld = div; mseen = 0;
                end
            end else begin
                mrej = 0;
                if (mk >= 24 && mseen && progdone) begin
                    mb = 0; mcm = mlm; mcd = mld;
                end else if (mk >= 24 && (mk - 24) == TMO - 1) begin
                    mb = 0;
                end else begin
                    if (mk >= 24 && !progdone) mseen = 1;
                    mk++;
                end
            end
        end
    end

    logic e_pe, e_pd, e_busy, e_done, e_err;

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && !rst) begin
                e_pe = 0; e_pd = 0; e_done = 0; e_err = mrej; e_busy = 0;
                if (mb) begin
                    e_err = 0;
                    if (mk >= 1 && mk <= 10) begin
                        e_pe = 1; e_pd = ser_bit(mk - 1, 1'b0, mld);
                    end else if (mk >= 12 && mk <= 21) begin
                        e_pe = 1; e_pd = ser_bit(mk - 12, 1'b1, mlm);
                    end else if (mk == 23) begin
                        e_pe = 1;
                    end
                    if (mk >= 24) begin
                        e_done = mseen && progdone;
                        e_err  = !e_done && ((mk - 24) == TMO - 1);
                    end
                    e_busy = !e_done && !e_err;
                end
                chk("progen", progen, e_pe);
                chk("progdata", progdata, e_pd);
                chk("busy", busy, e_busy);
                chk("done", done, e_done);
                chk("err", err, e_err);
                chk("cur_m", cur_m, mcm);
                chk("cur_d", cur_d, mcd);
                chk("done_err_excl", done & err, 0);
            end
        end
    end

    int          r_done, r_err;
    logic [31:0] r_pe;
    logic [9:0]  r_db, r_mb;
    logic        r_busy1;
    logic [15:0] r_cur0;

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            start = 0; progdone = 1;
            #3;
        end
    endtask

    // Start cycle is cycle 0; progdone is low for cycles lo..hi-1, high otherwise.
    task automatic run_seq(input logic [7:0] m, input logic [7:0] d, input int lo, input int hi,
                           input int sec_at, input logic [7:0] m2, input logic [7:0] d2);
        r_done = -1; r_err = -1; r_pe = '0; r_db = '0; r_mb = '0; r_busy1 = 0;
        @(posedge clk); #1;
        start = 1; mult = m; div = d; progdone = (0 < lo) || (0 >= hi);
        #3;
        r_cur0 = {cur_m, cur_d};
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            start = (c == sec_at);
            if (c == sec_at) begin
                mult = m2; div = d2;
            end
            progdone = (c < lo) || (c >= hi);
            #3;
            if (c < 32) r_pe[c] = progen;
            if (c >= 1 && c <= 10) r_db[c-1] = progdata;
            if (c >= 12 && c <= 21) r_mb[c-12] = progdata;
            if (c == 1) r_busy1 = busy;
            if (done && r_done < 0) r_done = c;
            if (err && r_err < 0) r_err = c;
            if (done || err) break;
        end
        start = 0;
        chk("seq_terminated", done | err, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_progen", progen, 0);
        chk("rst_progdata", progdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_cur_m", cur_m, 8'd2);
        chk("rst_cur_d", cur_d, 8'd0);
        rst = 0;
        chk_en = 1;
        idle(2);

        // Rejected request: mult == 0.
        run_seq(8'd0, 8'd5, 0, 0, -1, 8'd0, 8'd0);
        chk("rej_err_cycle", r_err, 1);
        chk("rej_busy", r_busy1, 0);
        chk("rej_progen", r_pe, 0);
        idle(2);
        chk("rej_cur_m", cur_m, 8'd2);

        // Nominal: mult=4, div=1, progdone low 25..29, high at 30.
        run_seq(8'd4, 8'd1, 25, 30, -1, 8'd0, 8'd0);
        chk("nom_progen_mask", r_pe, 32'h00BF_F7FE);
        chk("nom_d_bits", r_db, 10'h005);
        chk("nom_m_bits", r_mb, 10'h013);
        chk("nom_done_cycle", r_done, 30);

        // Back-to-back: start in the cycle right after done.
        run_seq(8'd9, 8'd3, 25, 30, -1, 8'd0, 8'd0);
        chk("nom_cur_after", r_cur0, {8'd4, 8'd1});
        chk("b2b_busy1", r_busy1, 1);
        chk("b2b_done_cycle", r_done, 30);

        // Timeout: progdone never drops.
        idle(1);
        run_seq(8'h10, 8'h20, 0, 0, -1, 8'd0, 8'd0);
        chk("b2b_cur_after", r_cur0, {8'd9, 8'd3});
        chk("to_err_cycle", r_err, 39);
        chk("to_no_done", r_done, -1);
        idle(1);
        chk("to_cur_kept", {cur_m, cur_d}, {8'd9, 8'd3});

        // Second start at cycle 5 is ignored.
        run_seq(8'hA5, 8'h3C, 25, 27, 5, 8'h01, 8'hFF);
        chk("ign_d_bits", r_db, 10'h0F1);
        chk("ign_m_bits", r_mb, 10'h297);
        chk("ign_done_cycle", r_done, 27);
        idle(1);
        chk("ign_cur", {cur_m, cur_d}, {8'hA5, 8'h3C});

        // Reset in the middle of LOAD_M.
        @(posedge clk); #1;
        start = 1; mult = 8'd4; div = 8'd1; progdone = 1;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk); #1;
            start = 0;
        end
        chk("pre_rst_progen", progen, 1);
        rst = 1;
        #1;
        chk("mid_rst_progen", progen, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_cur", {cur_m, cur_d}, {8'd2, 8'd0});
        #1;
        rst = 0;
        idle(3);
        run_seq(8'd7, 8'd2, 25, 28, -1, 8'd0, 8'd0);
        chk("post_rst_done_cycle", r_done, 28);
        idle(1);
        chk("post_rst_cur", {cur_m, cur_d}, {8'd7, 8'd2});
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
